// File: rtl/caliptra_fpga_clk_step_pkg.sv
// Shared types and defaults for the FPGA clock-step arbiter.
package caliptra_fpga_clk_step_pkg;

    // Default width of a step-count request.
    localparam int CNT_W_DEF = 32;

    // Step controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/caliptra_fpga_clk_step_arb_if.sv
// Request/step/status bundle between requesters and the clock-step arbiter.
interface caliptra_fpga_clk_step_arb_if
    import caliptra_fpga_clk_step_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = CNT_W_DEF
) ();
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CNT_W-1:0] req_cycles;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     abort;
    logic                     clk_en;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;
    logic [CNT_W-1:0]         remaining;
    logic                     done_valid;
    logic [ID_W-1:0]          done_id;
    logic                     done_aborted;
    logic [63:0]              total_cycles;

    // Requester / stimulus side.
    modport master (
        output req_valid, req_cycles, abort,
        input  req_ready, clk_en, busy, grant_id, remaining,
               done_valid, done_id, done_aborted, total_cycles
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_cycles, abort,
        output req_ready, clk_en, busy, grant_id, remaining,
               done_valid, done_id, done_aborted, total_cycles
    );
endinterface

// File: rtl/caliptra_fpga_rr_arb.sv
// Round-robin picker: search starts one past the previous winner.
module caliptra_fpga_rr_arb
    import caliptra_fpga_clk_step_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_req
);
    logic found;
    int   idx;

    assign any_req = |req;

    // First asserted request in rotating order wins; dropped requests are simply not seen.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/caliptra_fpga_clk_step_arb.sv
// Clock-step arbiter: grants one requester at a time a run of N enabled
// cycles of the stepped clock domain, with abort and completion reporting.
// Optional lifetime enabled-cycle counter: CALIPTRA_FPGA_CLK_STEP_CYC_CNT_EN.
module caliptra_fpga_clk_step_arb
    import caliptra_fpga_clk_step_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                         aclk,
    input  logic                         rstn,
    caliptra_fpga_clk_step_arb_if.slave  bus
);
    localparam int ID_W = id_w(NUM_REQ);

    state_e             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               aborted_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_req;
    logic               accept;
    logic [CNT_W-1:0]   win_cycles;

    caliptra_fpga_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any_req    (any_req)
    );

    // Ready only offered in IDLE; also held low while reset is asserted.
    assign bus.req_ready = (state == IDLE && rstn) ? gnt : '0;
    assign accept        = (state == IDLE) && any_req;
    assign win_cycles    = bus.req_cycles[int'(gnt_idx)*CNT_W +: CNT_W];

    assign bus.clk_en       = (state == RUN);
    assign bus.busy         = (state != IDLE);
    assign bus.done_valid   = (state == DONE);
    assign bus.done_aborted = (state == DONE) && aborted_q;
    assign bus.grant_id     = grant_q;
    assign bus.done_id      = grant_q;
    assign bus.remaining    = remaining_q;

    // Step FSM; RUN always holds remaining >= 1, so the decrement cannot underflow.
    // An abort still counts the current (enabled) cycle as run.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            grant_q     <= '0;
            remaining_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    grant_q     <= gnt_idx;
                    last_grant  <= gnt_idx;
                    remaining_q <= win_cycles;
                    aborted_q   <= 1'b0;
                    state       <= (win_cycles == '0) ? DONE : RUN;
                end
                RUN: begin
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        state     <= DONE;
                    end else if (remaining_q == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CALIPTRA_FPGA_CLK_STEP_CYC_CNT_EN
    logic [63:0] total_q;

    // Lifetime count of enabled cycles, wraps naturally at 2^64.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn)             total_q <= '0;
        else if (bus.clk_en)   total_q <= total_q + 64'd1;
    end

    assign bus.total_cycles = total_q;
`else
    assign bus.total_cycles = '0;
`endif

endmodule

// File: doc/caliptra_fpga_clk_step_arb.md
CALIPTRA_FPGA_CLK_STEP_ARB -- requirements
Module: caliptra_fpga_clk_step_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of step requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of a step-count request.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are named aclk and rstn.
REQ-004 aclk  input  1  sole clock; all state on posedge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester step request.
REQ-007 req_cycles  input  NUM_REQ*CNT_W  per-requester cycle count; slice i is bits [i*CNT_W +: CNT_W].
REQ-008 req_ready  output  NUM_REQ  one-hot accept; a request is taken when valid&ready.
REQ-009 abort  input  1  terminates the running step.
REQ-010 clk_en  output  1  gated-clock enable for the stepped domain.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 grant_id  output  $clog2(NUM_REQ)  owner of the current or last step.
REQ-013 remaining  output  CNT_W  cycles still to be enabled.
REQ-014 done_valid  output  1  one-cycle completion pulse.
REQ-015 done_id  output  $clog2(NUM_REQ)  requester that completed.
REQ-016 done_aborted  output  1  qualifies done_valid; the step was cut short.
REQ-017 total_cycles  output  64  count of cycles with clk_en high.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 In IDLE with any req_valid, the block SHALL assert req_ready combinationally for exactly one winner.
- Winner is chosen round-robin, starting at index last_grant+1 modulo NUM_REQ.
REQ-020 On accept at cycle T:
- grant_id and remaining SHALL load the winner's id and count at T+1.
- State SHALL become RUN at T+1, or DONE at T+1 if the count is 0.
REQ-021 In RUN, clk_en SHALL be high and remaining SHALL decrement each cycle.
- The step leaves RUN after remaining reaches 0, so clk_en is high for exactly N consecutive cycles (T+1..T+N).
REQ-022 DONE SHALL last one cycle, then return to IDLE.
- In DONE: done_valid=1, done_id=grant_id, clk_en=0.
- Normal completion: done_valid at T+N+1.
REQ-023 abort sampled high in RUN SHALL:
- drop clk_en the next cycle;
- enter DONE with done_aborted=1;
- leave remaining holding the un-run count.
REQ-024 abort outside RUN SHALL be ignored.
REQ-025 req_ready SHALL be 0 in RUN and DONE; a new request is accepted no earlier than the cycle after DONE.
REQ-026 Back-to-back requests SHALL alternate among active requesters, so no requester is starved for more than NUM_REQ-1 grants.
REQ-027 A requester that drops req_valid before being granted SHALL be skipped without error.
REQ-028 remaining SHALL never underflow below 0.
REQ-029 total_cycles SHALL increment by 1 on each cycle clk_en is high and wrap modulo 2^64.

Reset
REQ-030 rstn low SHALL asynchronously force:
- state=IDLE, last_grant=NUM_REQ-1;
- clk_en=0, busy=0, req_ready=0, done_valid=0, done_aborted=0;
- remaining=0, grant_id=0, done_id=0, total_cycles=0.
REQ-031 Reset asserted mid-RUN SHALL drop clk_en immediately, with no done_valid generated.

Configuration
REQ-032 Macro CALIPTRA_FPGA_CLK_STEP_CYC_CNT_EN SHALL control the total_cycles counter.
- Defined: the 64-bit total_cycles counter is implemented.
- Undefined: no counter flops exist; total_cycles is tied to 0.
- The port list is identical either way.

Structure
REQ-033 Package caliptra_fpga_clk_step_pkg SHALL hold the FSM state enum type and the default CNT_W constant.
REQ-034 Round-robin selection SHALL be a sub-module caliptra_fpga_rr_arb.
- Inputs: request vector, last grant.
- Outputs: one-hot grant, encoded index, any-request.

Verification
REQ-035 Single request with req_cycles[0]=5 accepted at T -> clk_en high T+1..T+5, done_valid at T+6 with done_id=0 and done_aborted=0; total_cycles=5 with the macro defined.
REQ-036 req_cycles=0 -> clk_en never high; done_valid at T+1.
REQ-037 Both requesters valid continuously, each with count 3 -> grants alternate 0,1,0,1; 4-cycle gap between accepts (3 enabled + 1 DONE).
REQ-038 count=100 with abort at the 10th clk_en cycle -> clk_en low the next cycle, done_aborted=1, remaining=90.
REQ-039 rstn pulsed low mid-RUN -> clk_en=0 asynchronously, no done_valid, outputs at reset values, the next grant goes to requester 0.
